// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if
// Bundles the three register-file write requesters (ALU, LD, FPU) and the
// shared write port into one interface.
//
// Signals
//   <req>_valid   requester holds a pending register-file write
//   <req>_ready   requester's write accepted this cycle
//   <req>_sel     target file: 01 GPR, 10 FPR, 00 no write, 11 illegal
//   <req>_dst     destination register index
//   <req>_data    write data
//   wb_regwrite   write-port select (00 none, 01 GPR, 10 FPR)
//   wb_regdst     write-port destination index
//   wb_data       write-port data
//   idle          no requester valid and no write on the port
//
// Modports
//   master  requester / register-file side (drives requests, sees results)
//   slave   arbiter side
interface wb_arbiter_if;
  logic        alu_valid;
  logic        ld_valid;
  logic        fpu_valid;

  logic        alu_ready;
  logic        ld_ready;
  logic        fpu_ready;

  logic [1:0]  alu_sel;
  logic [1:0]  ld_sel;
  logic [1:0]  fpu_sel;

  logic [4:0]  alu_dst;
  logic [4:0]  ld_dst;
  logic [4:0]  fpu_dst;

  logic [31:0] alu_data;
  logic [31:0] ld_data;
  logic [31:0] fpu_data;

  logic [1:0]  wb_regwrite;
  logic [4:0]  wb_regdst;
  logic [31:0] wb_data;
  logic        idle;

  modport master (
    output alu_valid, ld_valid, fpu_valid,
    output alu_sel, ld_sel, fpu_sel,
    output alu_dst, ld_dst, fpu_dst,
    output alu_data, ld_data, fpu_data,
    input  alu_ready, ld_ready, fpu_ready,
    input  wb_regwrite, wb_regdst, wb_data, idle
  );

  modport slave (
    input  alu_valid, ld_valid, fpu_valid,
    input  alu_sel, ld_sel, fpu_sel,
    input  alu_dst, ld_dst, fpu_dst,
    input  alu_data, ld_data, fpu_data,
    output alu_ready, ld_ready, fpu_ready,
    output wb_regwrite, wb_regdst, wb_data, idle
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter
// Arbitrates three register-file write requesters (ALU, LD, FPU) onto a
// single shared write port. Grant and ready are combinational; the winning
// write is registered and appears on the port for exactly one cycle after
// the grant.
//
// Ports
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset
//   bus   wb_arbiter_if.slave (requests in, ready and write port out)
//
// Parameters
//   R0_DISCARD  1: GPR writes to register 0 are acked but not written
//               0: GPR register 0 writes pass through
//
// Configuration macro
//   WB_RR_EN    defined: round-robin arbitration using a last-grant pointer
//               undefined: fixed priority ALU > LD > FPU
//
// Arbitration pointer (only with WB_RR_EN):
//   state  | meaning
//   LG_ALU | ALU granted last; search order LD, FPU, ALU
//   LG_LD  | LD granted last;  search order FPU, ALU, LD
//   LG_FPU | FPU granted last (reset value); search order ALU, LD, FPU
module wb_arbiter #(
  parameter int unsigned R0_DISCARD = 1
) (
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus
);

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_GPR  = 2'b01;
  localparam logic [1:0] SEL_FPR  = 2'b10;
  localparam bit         R0_DROP  = (R0_DISCARD != 0);

  // Requester index: 0 = ALU, 1 = LD, 2 = FPU
  logic [2:0]       req_valid;
  logic [2:0][1:0]  req_sel;
  logic [2:0][4:0]  req_dst;
  logic [2:0][31:0] req_data;

  logic [2:0]       eligible;
  logic [2:0]       bypass;
  logic [2:0]       grant;

  logic [1:0]       gnt_sel;
  logic [4:0]       gnt_dst;
  logic [31:0]      gnt_data;
  logic             gnt_discard;
  logic             write_en;

  logic [1:0]       wr_sel_q;
  logic [4:0]       wr_dst_q;
  logic [31:0]      wr_data_q;
  logic [1:0]       port_sel;

  assign req_valid = {bus.fpu_valid, bus.ld_valid, bus.alu_valid};
  assign req_sel   = {bus.fpu_sel,   bus.ld_sel,   bus.alu_sel};
  assign req_dst   = {bus.fpu_dst,   bus.ld_dst,   bus.alu_dst};
  assign req_data  = {bus.fpu_data,  bus.ld_data,  bus.alu_data};

  // Eligible requests compete for the port; "no write" and illegal selects
  // are simply acknowledged without consuming the grant.
  always_comb begin
    eligible = '0;
    bypass   = '0;
    for (int i = 0; i < 3; i++) begin
      eligible[i] = req_valid[i] & ((req_sel[i] == SEL_GPR) | (req_sel[i] == SEL_FPR));
      bypass[i]   = req_valid[i] & ~((req_sel[i] == SEL_GPR) | (req_sel[i] == SEL_FPR));
    end
  end

`ifdef WB_RR_EN
  typedef enum logic [1:0] {
    LG_ALU = 2'd0,
    LG_LD  = 2'd1,
    LG_FPU = 2'd2
  } last_grant_e;

  last_grant_e last_q;
  last_grant_e last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= LG_FPU;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    grant  = '0;
    last_d = last_q;
    if (!rst) begin
      case (last_q)
        LG_ALU: begin
          if      (eligible[1]) grant = 3'b010;
          else if (eligible[2]) grant = 3'b100;
          else if (eligible[0]) grant = 3'b001;
        end
        LG_LD: begin
          if      (eligible[2]) grant = 3'b100;
          else if (eligible[0]) grant = 3'b001;
          else if (eligible[1]) grant = 3'b010;
        end
        default: begin
          if      (eligible[0]) grant = 3'b001;
          else if (eligible[1]) grant = 3'b010;
          else if (eligible[2]) grant = 3'b100;
        end
      endcase
    end
    // Pointer only moves when a grant is actually issued.
    case (grant)
      3'b001:  last_d = LG_ALU;
      3'b010:  last_d = LG_LD;
      3'b100:  last_d = LG_FPU;
      default: last_d = last_q;
    endcase
  end
`else
  always_comb begin
    grant = '0;
    if (!rst) begin
      if      (eligible[0]) grant = 3'b001;
      else if (eligible[1]) grant = 3'b010;
      else if (eligible[2]) grant = 3'b100;
    end
  end
`endif

  assign bus.alu_ready = ~rst & (grant[0] | bypass[0]);
  assign bus.ld_ready  = ~rst & (grant[1] | bypass[1]);
  assign bus.fpu_ready = ~rst & (grant[2] | bypass[2]);

  // grant is one-hot or zero, so an OR-mux selects the winner's payload.
  always_comb begin
    gnt_sel  = SEL_NONE;
    gnt_dst  = '0;
    gnt_data = '0;
    for (int i = 0; i < 3; i++) begin
      if (grant[i]) begin
        gnt_sel  = gnt_sel  | req_sel[i];
        gnt_dst  = gnt_dst  | req_dst[i];
        gnt_data = gnt_data | req_data[i];
      end
    end
  end

  // A granted GPR write to r0 is acked normally but never reaches the port.
  assign gnt_discard = R0_DROP & (gnt_sel == SEL_GPR) & (gnt_dst == 5'd0);
  assign write_en    = (|grant) & ~gnt_discard;

  // Select lasts one cycle; index and data hold until the next real write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel_q  <= SEL_NONE;
      wr_dst_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_sel_q <= write_en ? gnt_sel : SEL_NONE;
      if (write_en) begin
        wr_dst_q  <= gnt_dst;
        wr_data_q <= gnt_data;
      end
    end
  end

  // While reset is held the port is forced quiet, which also drops a write
  // that was registered in the cycle just before reset rose.
  assign port_sel        = rst ? SEL_NONE : wr_sel_q;
  assign bus.wb_regwrite = port_sel;
  assign bus.wb_regdst   = rst ? 5'd0  : wr_dst_q;
  assign bus.wb_data     = rst ? 32'd0 : wr_data_q;
  assign bus.idle        = ~(|req_valid) & (port_sel == SEL_NONE);

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: reset checks, a vector table applied
// from a fresh reset, hand-written multi-cycle sequences, then randomized
// traffic compared against a behavioural model of the arbitration rules.
module tb_wb_arbiter;

  localparam int R0D = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if bus();

  wb_arbiter #(.R0_DISCARD(R0D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Driven requester state, index 0 = ALU, 1 = LD, 2 = FPU
  bit         tv   [3];
  bit [1:0]   ts   [3];
  bit [4:0]   td   [3];
  bit [31:0]  tdat [3];

  // Behavioural model
  int         m_last;
  int         m_gnt;
  bit [2:0]   m_rdy;
  bit [1:0]   m_we;
  bit [4:0]   m_dst;
  bit [31:0]  m_data;
  int         wait_cnt [3];

  typedef struct {
    bit [2:0]  v;      // {fpu, ld, alu}
    bit [1:0]  s0, s1, s2;
    bit [4:0]  d0, d1, d2;
    bit [31:0] x0, x1, x2;
    bit [2:0]  rdy;    // {fpu, ld, alu}
    bit [1:0]  we;
    bit [4:0]  wdst;
    bit [31:0] wdata;
  } vec_t;

  vec_t vec [12];

  function automatic vec_t mk(bit [2:0] v, bit [1:0] s0, bit [1:0] s1, bit [1:0] s2,
                              bit [4:0] d0, bit [4:0] d1, bit [4:0] d2,
                              bit [31:0] x0, bit [31:0] x1, bit [31:0] x2,
                              bit [2:0] rdy, bit [1:0] we, bit [4:0] wdst, bit [31:0] wdata);
    vec_t r;
    r.v = v; r.s0 = s0; r.s1 = s1; r.s2 = s2;
    r.d0 = d0; r.d1 = d1; r.d2 = d2;
    r.x0 = x0; r.x1 = x1; r.x2 = x2;
    r.rdy = rdy; r.we = we; r.wdst = wdst; r.wdata = wdata;
    return r;
  endfunction

  task automatic apply();
    bus.alu_valid = tv[0]; bus.alu_sel = ts[0]; bus.alu_dst = td[0]; bus.alu_data = tdat[0];
    bus.ld_valid  = tv[1]; bus.ld_sel  = ts[1]; bus.ld_dst  = td[1]; bus.ld_data  = tdat[1];
    bus.fpu_valid = tv[2]; bus.fpu_sel = ts[2]; bus.fpu_dst = td[2]; bus.fpu_data = tdat[2];
  endtask

  task automatic set_req(int i, bit v, bit [1:0] s, bit [4:0] d, bit [31:0] x);
    tv[i] = v; ts[i] = s; td[i] = d; tdat[i] = x;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 2'b00, 5'd0, 32'd0);
  endtask

  function automatic logic [2:0] dut_rdy();
    return {bus.fpu_ready, bus.ld_ready, bus.alu_ready};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int cycles);
    rst = 1'b1;
    clear_reqs();
    apply();
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic bit is_elig(int i);
    return tv[i] && (ts[i] == 2'b01 || ts[i] == 2'b10);
  endfunction

  // Winner and ready set for the current inputs, straight from the rules:
  // search the eligible requesters in order, acknowledge every valid
  // no-write/illegal request, nothing while reset is held.
  task automatic model_eval();
    m_gnt = -1;
    if (!rst) begin
`ifdef WB_RR_EN
      for (int k = 1; k <= 3; k++) begin
        if (m_gnt < 0 && is_elig((m_last + k) % 3)) m_gnt = (m_last + k) % 3;
      end
`else
      for (int j = 0; j < 3; j++) begin
        if (m_gnt < 0 && is_elig(j)) m_gnt = j;
      end
`endif
    end
    m_rdy = '0;
    for (int i = 0; i < 3; i++)
      m_rdy[i] = !rst && ((tv[i] && !is_elig(i)) || m_gnt == i);
  endtask

  task automatic model_commit();
    if (rst) begin
      m_last = 2; m_we = 2'b00; m_dst = '0; m_data = '0;
    end else if (m_gnt >= 0) begin
      m_last = m_gnt;
      if (R0D != 0 && ts[m_gnt] == 2'b01 && td[m_gnt] == 5'd0) begin
        m_we = 2'b00;
      end else begin
        m_we = ts[m_gnt]; m_dst = td[m_gnt]; m_data = tdat[m_gnt];
      end
    end else begin
      m_we = 2'b00;
    end
  endtask

  task automatic check_cycle();
    bit [1:0] ewe;
    ewe = rst ? 2'b00 : m_we;
    model_eval();
    check("rnd_ready", dut_rdy(), m_rdy);
    check("rnd_regwrite", bus.wb_regwrite, ewe);
    if (ewe != 2'b00) begin
      check("rnd_regdst", bus.wb_regdst, m_dst);
      check("rnd_data", bus.wb_data, m_data);
    end
    check("rnd_idle", bus.idle, !(tv[0] || tv[1] || tv[2]) && ewe == 2'b00);
  endtask

  task automatic new_req(int i);
    int r;
    bit [1:0] s;
    r = $urandom_range(0, 9);
    if (r == 0)      s = 2'b00;
    else if (r == 1) s = 2'b11;
    else if (r < 6)  s = 2'b01;
    else             s = 2'b10;
    set_req(i, 1'b1, s,
            $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31)),
            $urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [2:0] exp_r;
    bit [2:0] r;
    int       prev;

    vec[0]  = mk(3'b001, 2'b01, 2'b00, 2'b00, 5'd5, 5'd0, 5'd0, 32'h0000_1234, 0, 0, 3'b001, 2'b01, 5'd5, 32'h0000_1234);
    vec[1]  = mk(3'b110, 2'b00, 2'b01, 2'b00, 5'd0, 5'd0, 5'd0, 0, 32'hFFFF_FFFF, 0, 3'b110, 2'b00, 5'd0, 0);
    vec[2]  = mk(3'b010, 2'b00, 2'b10, 2'b00, 5'd0, 5'd31, 5'd0, 0, 32'hA5A5_0001, 0, 3'b010, 2'b10, 5'd31, 32'hA5A5_0001);
    vec[3]  = mk(3'b111, 2'b01, 2'b10, 2'b10, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 3'b001, 2'b01, 5'd1, 32'h11);
    vec[4]  = mk(3'b110, 2'b00, 2'b01, 2'b10, 5'd0, 5'd12, 5'd13, 0, 32'hC0DE, 32'hBEEF, 3'b010, 2'b01, 5'd12, 32'hC0DE);
    vec[5]  = mk(3'b100, 2'b00, 2'b00, 2'b10, 5'd0, 5'd0, 5'd3, 0, 0, 32'hDEAD_BEEF, 3'b100, 2'b10, 5'd3, 32'hDEAD_BEEF);
    vec[6]  = mk(3'b011, 2'b11, 2'b01, 2'b00, 5'd4, 5'd9, 5'd0, 32'h44, 32'h99, 0, 3'b011, 2'b01, 5'd9, 32'h99);
    vec[7]  = mk(3'b000, 2'b01, 2'b01, 2'b10, 5'd1, 5'd2, 5'd3, 1, 2, 3, 3'b000, 2'b00, 5'd0, 0);
    vec[8]  = mk(3'b001, 2'b01, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 32'h77, 0, 0, 3'b001, 2'b00, 5'd0, 0);
    vec[9]  = mk(3'b100, 2'b00, 2'b00, 2'b10, 5'd0, 5'd0, 5'd0, 0, 0, 32'h55, 3'b100, 2'b10, 5'd0, 32'h55);
    vec[10] = mk(3'b111, 2'b00, 2'b11, 2'b00, 5'd1, 5'd2, 5'd3, 1, 2, 3, 3'b111, 2'b00, 5'd0, 0);
    vec[11] = mk(3'b101, 2'b00, 2'b00, 2'b10, 5'd8, 5'd0, 5'd30, 32'h8, 0, 32'hF00D, 3'b101, 2'b10, 5'd30, 32'hF00D);

    // Reset state, with requests pending that must not be acked
    rst = 1'b1;
    clear_reqs();
    set_req(0, 1'b1, 2'b01, 5'd3, 32'h3);
    set_req(1, 1'b1, 2'b00, 5'd0, 32'h0);
    apply();
    @(negedge clk);
    check("rst_ready", dut_rdy(), 3'b000);
    check("rst_regwrite", bus.wb_regwrite, 2'b00);
    check("rst_regdst", bus.wb_regdst, 5'd0);
    check("rst_data", bus.wb_data, 32'd0);
    check("rst_idle_busy", bus.idle, 1'b0);
    next_cycle();
    clear_reqs();
    apply();
    @(negedge clk);
    check("rst_idle", bus.idle, 1'b1);
    next_cycle();

    // Vector table, each from a fresh reset (pointer at FPU)
    for (int k = 0; k < 12; k++) begin
      do_reset(1);
      set_req(0, vec[k].v[0], vec[k].s0, vec[k].d0, vec[k].x0);
      set_req(1, vec[k].v[1], vec[k].s1, vec[k].d1, vec[k].x1);
      set_req(2, vec[k].v[2], vec[k].s2, vec[k].d2, vec[k].x2);
      apply();
      @(negedge clk);
      check($sformatf("v%0d_ready", k), dut_rdy(), vec[k].rdy);
      next_cycle();
      clear_reqs();
      apply();
      @(negedge clk);
      check($sformatf("v%0d_regwrite", k), bus.wb_regwrite, vec[k].we);
      if (vec[k].we != 2'b00) begin
        check($sformatf("v%0d_regdst", k), bus.wb_regdst, vec[k].wdst);
        check($sformatf("v%0d_data", k), bus.wb_data, vec[k].wdata);
        next_cycle();
        @(negedge clk);
        check($sformatf("v%0d_once", k), bus.wb_regwrite, 2'b00);
        check($sformatf("v%0d_hold_dst", k), bus.wb_regdst, vec[k].wdst);
        check($sformatf("v%0d_hold_data", k), bus.wb_data, vec[k].wdata);
      end
      next_cycle();
    end

    // All three continuously valid from reset release
    do_reset(1);
    set_req(0, 1'b1, 2'b01, 5'd1, 32'hA0);
    set_req(1, 1'b1, 2'b01, 5'd2, 32'hB0);
    set_req(2, 1'b1, 2'b10, 5'd3, 32'hC0);
    apply();
    prev = -1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
`ifdef WB_RR_EN
      exp_r = 3'b001 << (c % 3);
`else
      exp_r = 3'b001;
`endif
      check("contend_ready", dut_rdy(), exp_r);
      if (prev >= 0) begin
        check("contend_regdst", bus.wb_regdst, 5'(prev + 1));
        check("contend_regwrite", bus.wb_regwrite, (prev == 2) ? 2'b10 : 2'b01);
      end
      for (int i = 0; i < 3; i++) if (exp_r[i]) prev = i;
      next_cycle();
    end
    clear_reqs();
    apply();
    next_cycle();

    // Reset mid-operation: in-flight write dropped, held request granted after
    do_reset(1);
    set_req(0, 1'b1, 2'b01, 5'd4, 32'h44);
    apply();
    @(negedge clk);
    check("midrst_first_ready", dut_rdy(), 3'b001);
    next_cycle();
    rst = 1'b1;
    set_req(0, 1'b1, 2'b01, 5'd6, 32'h66);
    apply();
    @(negedge clk);
    check("midrst_drop", bus.wb_regwrite, 2'b00);
    check("midrst_noack", dut_rdy(), 3'b000);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_after", bus.wb_regwrite, 2'b00);
    check("midrst_regrant", dut_rdy(), 3'b001);
    next_cycle();
    clear_reqs();
    apply();
    @(negedge clk);
    check("midrst_wr_sel", bus.wb_regwrite, 2'b01);
    check("midrst_wr_dst", bus.wb_regdst, 5'd6);
    check("midrst_wr_data", bus.wb_data, 32'h66);
    next_cycle();

    // Same destination from two requesters: both written, in grant order
    do_reset(1);
    set_req(0, 1'b1, 2'b01, 5'd7, 32'd1);
    set_req(2, 1'b1, 2'b10, 5'd7, 32'd2);
    apply();
    @(negedge clk);
    check("samedst_ready0", dut_rdy(), 3'b001);
    next_cycle();
    set_req(0, 1'b0, 2'b00, 5'd0, 32'd0);
    apply();
    @(negedge clk);
    check("samedst_gpr_sel", bus.wb_regwrite, 2'b01);
    check("samedst_gpr_dst", bus.wb_regdst, 5'd7);
    check("samedst_gpr_data", bus.wb_data, 32'd1);
    check("samedst_ready1", dut_rdy(), 3'b100);
    next_cycle();
    clear_reqs();
    apply();
    @(negedge clk);
    check("samedst_fpr_sel", bus.wb_regwrite, 2'b10);
    check("samedst_fpr_dst", bus.wb_regdst, 5'd7);
    check("samedst_fpr_data", bus.wb_data, 32'd2);
    next_cycle();

    // Randomized traffic against the model
    do_reset(1);
    m_last = 2; m_we = 2'b00; m_dst = '0; m_data = '0;
    for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      check_cycle();
      r = dut_rdy();
`ifdef WB_RR_EN
      for (int i = 0; i < 3; i++) begin
        if (rst || !is_elig(i) || r[i]) wait_cnt[i] = 0;
        else wait_cnt[i]++;
        if (is_elig(i) && !rst) check("rr_wait_bound", 32'(wait_cnt[i] < 3), 32'd1);
      end
`endif
      @(posedge clk);
      model_commit();
      #1;
      for (int i = 0; i < 3; i++) begin
        if (tv[i] && m_rdy[i]) tv[i] = 1'b0;
        if (!tv[i] && $urandom_range(0, 2) != 0) new_req(i);
      end
      rst = ($urandom_range(0, 63) == 0);
      apply();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
